// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern serializer.
// Macro PATTERN_SER_PARITY_EN adds the S_PAR state used for the trailing even-parity bit.
package pattern_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010
`ifdef PATTERN_SER_PARITY_EN
    ,
    S_PAR   = 3'b100
`endif
  } state_t;

  localparam logic B = 1'b1;
  localparam logic C = 1'b0;

  // Even parity over a zero-extended word; the extension bits do not change the XOR.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pattern_ser_cnt.sv
// Bit counter for the serializer: counts emitted data bits, saturating at WIDTH.
// clr restarts the count; clr together with inc restarts at one.
module pattern_ser_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(WIDTH));

  // Count register; never passes WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= inc ? CW'(1) : {CW{1'b0}};
    end else if (inc && !last) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial converter feeding a downstream pattern detector, with registered outputs.
// Define PATTERN_SER_PARITY_EN to append an even-parity bit after each word.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en_i,
  output logic             data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             word_done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] sr_r, sr_next_s;
  logic [CW-1:0]    cnt_s;
  logic             cnt_last_s, cnt_clr_s, cnt_inc_s;
  logic             accept_s, emit_s, emit_bit_s, final_s, done_s;
`ifdef PATTERN_SER_PARITY_EN
  logic             par_r;
`endif

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  pattern_ser_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .inc  (cnt_inc_s),
    .cnt  (cnt_s),
    .last (cnt_last_s)
  );

  assign accept_s = in_valid & in_ready;
  // The final bit is on data_o this cycle, so a new word may be taken without a gap.
`ifdef PATTERN_SER_PARITY_EN
  assign done_s = (state_r == S_PAR);
`else
  assign done_s = (state_r == S_SHIFT) && cnt_last_s;
`endif

  // Next-state, shift-register and emitted-bit decode.
  always_comb begin
    state_next_s = state_r;
    sr_next_s    = sr_r;
    emit_s       = 1'b0;
    emit_bit_s   = C;
    final_s      = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    if ((state_r == S_IDLE) || done_s) begin
      cnt_clr_s = 1'b1;
      if (accept_s) begin
        state_next_s = S_SHIFT;
        if (en_i) begin
          emit_s     = 1'b1;
          emit_bit_s = head_bit(in_data);
          sr_next_s  = shift_out(in_data);
          cnt_inc_s  = 1'b1;
        end else begin
          sr_next_s = in_data;
        end
      end else begin
        state_next_s = S_IDLE;
      end
    end else begin
      case (state_r)
        S_SHIFT: begin
          if (en_i) begin
`ifdef PATTERN_SER_PARITY_EN
            if (cnt_last_s) begin
              emit_s       = 1'b1;
              emit_bit_s   = par_r;
              final_s      = 1'b1;
              state_next_s = S_PAR;
            end else begin
              emit_s     = 1'b1;
              emit_bit_s = head_bit(sr_r);
              sr_next_s  = shift_out(sr_r);
              cnt_inc_s  = 1'b1;
            end
`else
            emit_s     = 1'b1;
            emit_bit_s = head_bit(sr_r);
            sr_next_s  = shift_out(sr_r);
            cnt_inc_s  = 1'b1;
            final_s    = (cnt_s == CW'(WIDTH - 1));
`endif
          end else begin
            state_next_s = state_r;
          end
        end
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      sr_r        <= {WIDTH{1'b0}};
      data_o      <= C;
      valid_o     <= 1'b0;
      word_done_o <= 1'b0;
      busy_o      <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      sr_r        <= sr_next_s;
      data_o      <= emit_bit_s;
      valid_o     <= emit_s;
      word_done_o <= final_s;
      busy_o      <= (state_next_s != S_IDLE);
      in_ready    <= (state_next_s == S_IDLE) | final_s;
    end
  end

`ifdef PATTERN_SER_PARITY_EN
  // Parity of the accepted word, sent after its data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_r <= 1'b0;
    end else if (accept_s) begin
      par_r <= even_parity(32'(in_data));
    end else begin
      par_r <= par_r;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue-based model of the emitted bit stream.
module tb_pattern_serializer;

  localparam int W = 8;
`ifdef PATTERN_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         en_i = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_m, dat_m, val_m, busy_m, done_m;
  logic rdy_l, dat_l, val_l, busy_l, done_l;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .en_i(en_i), .data_o(dat_m), .valid_o(val_m), .busy_o(busy_m), .word_done_o(done_m)
  );

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .en_i(en_i), .data_o(dat_l), .valid_o(val_l), .busy_o(busy_l), .word_done_o(done_l)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: the bits still owed for the current word, in transmission order.
  bit q_m[$];
  bit q_l[$];
  bit m_ready, m_busy, m_valid, m_done, m_dm, m_dl, m_accept;

  logic [31:0] col_m, col_l;
  int nvalid;

  function automatic void model_reset();
    q_m.delete();
    q_l.delete();
    m_ready = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
    m_dm = 1'b0; m_dl = 1'b0; m_accept = 1'b0;
  endfunction

  function automatic void model_edge();
    m_accept = m_ready && in_valid;
    m_valid = 1'b0; m_done = 1'b0; m_dm = 1'b0; m_dl = 1'b0;
    if (m_accept) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(in_data[W-1-i]);
        q_l.push_back(in_data[i]);
      end
      if (PB == 1) begin
        q_m.push_back(^in_data);
        q_l.push_back(^in_data);
      end
    end
    if (en_i && q_m.size() > 0) begin
      m_valid = 1'b1;
      m_dm = q_m.pop_front();
      m_dl = q_l.pop_front();
      m_done = (q_m.size() == 0);
    end
    m_ready = (q_m.size() == 0);
    m_busy = (q_m.size() > 0) || m_done;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("msb_outs{rdy,busy,done,valid,data}", {27'd0, rdy_m, busy_m, done_m, val_m, dat_m},
        {27'd0, m_ready, m_busy, m_done, m_valid, m_dm});
    chk("lsb_outs{rdy,busy,done,valid,data}", {27'd0, rdy_l, busy_l, done_l, val_l, dat_l},
        {27'd0, m_ready, m_busy, m_done, m_valid, m_dl});
    if (val_m) begin
      col_m = {col_m[30:0], dat_m};
      nvalid++;
    end
    if (val_l) col_l = {col_l[30:0], dat_l};
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check_outs();
  endtask

  task automatic clear_col();
    col_m = 32'd0;
    col_l = 32'd0;
    nvalid = 0;
  endtask

  task automatic send(input logic [W-1:0] w);
    int guard;
    guard = 0;
    in_data = w;
    in_valid = 1'b1;
    do begin
      step();
      guard++;
    end while (!m_accept && guard < 50);
    chk("send_accepted", {31'd0, m_accept}, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] mask_bits(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = (32'd1 << n) - 32'd1;
    return v & m;
  endfunction

  initial begin
    model_reset();
    clear_col();
    // Reset: everything low, including in_ready.
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, rdy_m}, 32'd1);

    // 0xD0: MSB-first 11010000, word_done on the eighth bit.
    en_i = 1'b1;
    clear_col();
    send(8'hD0);
    repeat (9) step();
    chk("d0_msb_bits", mask_bits(col_m, W + PB), (32'hD0 << PB) | PB);
    chk("d0_lsb_bits", mask_bits(col_l, W + PB), (32'h0B << PB) | PB);

    // 0x0B: LSB-first instance must give 11010000.
    clear_col();
    send(8'h0B);
    repeat (9) step();
    chk("0b_lsb_bits", mask_bits(col_l, W + PB), (32'hD0 << PB) | PB);
    chk("0b_msb_bits", mask_bits(col_m, W + PB), (32'h0B << PB) | PB);

    // Back-to-back 0xA5 then 0x3C with no gap.
    clear_col();
    send(8'hA5);
    in_data = 8'h3C;
    in_valid = 1'b1;
    send(8'h3C);
    repeat (10) step();
    chk("b2b_count", nvalid, 2 * (W + PB));
    chk("b2b_bits", mask_bits(col_m, 2 * (W + PB)), ((32'hA5 << (W + PB)) | (32'h3C)) << PB);

    // Stall three cycles after bit 3 of 0xFF.
    clear_col();
    send(8'hFF);
    repeat (2) step();
    en_i = 1'b0;
    repeat (3) step();
    chk("stall_bits_before_resume", nvalid, 3);
    en_i = 1'b1;
    repeat (10) step();
    chk("stall_count", nvalid, W + PB);
    chk("stall_bits", mask_bits(col_m, W + PB), 32'hFF << PB);

    // Asynchronous reset after bit 5, then a fresh word.
    send(8'h5A);
    repeat (4) step();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_outs();
    step();
    @(negedge clk);
    rst = 1'b1;
    clear_col();
    send(8'h80);
    repeat (9) step();
    chk("after_reset_bits", mask_bits(col_m, W + PB), (32'h80 << PB) | PB);
    chk("after_reset_count", nvalid, W + PB);

    // Random traffic and enable pattern.
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (m_accept || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = W'($urandom);
      end
      en_i = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
